// File: rtl/patbuf_sequencer_if.sv
// rtl/patbuf_sequencer_if.sv - signal bundle between host, patbuf_sequencer and the pattern buffer
//
// Groups the host command/write/readback handshakes and the pattern-buffer
// side pointers into one bundle.
//   slave  : the sequencer (drives cmd_ready, wr_ready, rd_*, bufp, fieldp,
//            fieldwp, field_in, field_write, busy, done)
//   master : the environment (host front end plus pattern buffer; drives
//            cmd_*, wr_valid, wr_data, field_byte_in)
interface patbuf_sequencer_if #(
  parameter int BUFFER_SIZE  = 12,
  parameter int BUFFER_WIDTH = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_op;
  logic [2:0]              cmd_buf;
  logic                    wr_valid;
  logic [BUFFER_WIDTH-1:0] wr_data;
  logic                    wr_ready;
  logic                    rd_valid;
  logic [BUFFER_WIDTH-1:0] rd_data;
  logic [BUFFER_WIDTH-1:0] field_byte_in;
  logic [2:0]              bufp;
  logic [BUFFER_SIZE-1:0]  fieldp;
  logic [BUFFER_SIZE-1:0]  fieldwp;
  logic [BUFFER_WIDTH-1:0] field_in;
  logic                    field_write;
  logic                    busy;
  logic                    done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_buf, wr_valid, wr_data, field_byte_in,
    output cmd_ready, wr_ready, rd_valid, rd_data, bufp, fieldp, fieldwp,
           field_in, field_write, busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_buf, wr_valid, wr_data, field_byte_in,
    input  cmd_ready, wr_ready, rd_valid, rd_data, bufp, fieldp, fieldwp,
           field_in, field_write, busy, done
  );
endinterface

// File: rtl/patbuf_sequencer.sv
// rtl/patbuf_sequencer.sv - load/readback sequencer for the pattern buffer store
//
// Takes one host command at a time: fill a buffer with BUFFER_SIZE bytes, or
// walk the one-hot read pointer across it and return the bytes after RD_LAT.
// Ports:
//   clk    : system clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : patbuf_sequencer_if.slave
//            host side    cmd_valid/cmd_ready/cmd_op/cmd_buf,
//                         wr_valid/wr_ready/wr_data, rd_valid/rd_data,
//                         busy, done
//            buffer side  bufp, fieldp, fieldwp, field_in, field_write
//                         (all registered), field_byte_in
module patbuf_sequencer #(
  parameter int BUFFER_SIZE  = 12,
  parameter int BUFFER_WIDTH = 8,
  parameter int NO_BUFS      = 8,
  parameter int RD_LAT       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  patbuf_sequencer_if.slave   bus
);
  localparam int IDX_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BUFFER_SIZE - 1);
  localparam logic [RD_LAT-1:0] TOP_BIT  = RD_LAT'(1) << (RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                  state, state_d;
  logic [IDX_W-1:0]        idx, idx_d;
  logic [2:0]              bufp_q, bufp_d;
  logic [BUFFER_SIZE-1:0]  fieldp_q, fieldp_d;
  logic [BUFFER_SIZE-1:0]  fieldwp_q, fieldwp_d;
  logic [BUFFER_WIDTH-1:0] field_in_q, field_in_d;
  logic                    field_write_q, field_write_d;
  logic                    wr_done_q, wr_done_d;
  logic [RD_LAT-1:0]       vpipe_q, vpipe_d;
  logic [2:0]              buf_sel;
  logic                    rd_valid;
  logic                    rd_done;

  function automatic logic [BUFFER_SIZE-1:0] onehot(input logic [IDX_W-1:0] i);
    return BUFFER_SIZE'(1) << i;
  endfunction

  // With 8 buffers every 3-bit index is legal; fewer buffers fold the index.
  assign buf_sel = (NO_BUFS >= 8) ? bus.cmd_buf : 3'(int'(bus.cmd_buf) % NO_BUFS);

  // vpipe_q[k] set means a read issued k+1 cycles ago; the top bit lines up
  // with the pattern buffer's registered output.
  assign rd_valid = vpipe_q[RD_LAT-1];
  // Read completes on the last returning byte: nothing else still in flight.
  assign rd_done  = (state == DRAIN) && rd_valid && ((vpipe_q & ~TOP_BIT) == '0);

  always_comb begin
    state_d       = state;
    idx_d         = idx;
    bufp_d        = bufp_q;
    fieldp_d      = '0;
    fieldwp_d     = '0;
    field_in_d    = field_in_q;
    field_write_d = 1'b0;
    wr_done_d     = 1'b0;
    // fieldp_q is non-zero exactly while in READ, so this records each issue.
    vpipe_d       = RD_LAT'({vpipe_q, state == READ});

    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          bufp_d = buf_sel;
          idx_d  = '0;
          if (bus.cmd_op) begin
            state_d  = READ;
            // fieldp is registered, so field 0 is issued on the accept edge.
            fieldp_d = onehot('0);
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (bus.wr_valid) begin
          field_write_d = 1'b1;
          fieldwp_d     = onehot(idx);
          field_in_d    = bus.wr_data;
          if (idx == LAST_IDX) begin
            state_d   = IDLE;
            idx_d     = '0;
            wr_done_d = 1'b1;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      READ: begin
        // idx is the field whose pointer is on the bus this cycle.
        if (idx == LAST_IDX) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          idx_d    = idx + 1'b1;
          fieldp_d = onehot(idx + 1'b1);
        end
      end
      DRAIN: begin
        if (rd_done || (vpipe_q == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      bufp_q        <= '0;
      fieldp_q      <= '0;
      fieldwp_q     <= '0;
      field_in_q    <= '0;
      field_write_q <= 1'b0;
      wr_done_q     <= 1'b0;
      vpipe_q       <= '0;
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      bufp_q        <= bufp_d;
      fieldp_q      <= fieldp_d;
      fieldwp_q     <= fieldwp_d;
      field_in_q    <= field_in_d;
      field_write_q <= field_write_d;
      wr_done_q     <= wr_done_d;
      vpipe_q       <= vpipe_d;
    end
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.wr_ready    = (state == WRITE);
  assign bus.busy        = (state != IDLE);
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_data     = rd_valid ? bus.field_byte_in : '0;
  assign bus.bufp        = bufp_q;
  assign bus.fieldp      = fieldp_q;
  assign bus.fieldwp     = fieldwp_q;
  assign bus.field_in    = field_in_q;
  assign bus.field_write = field_write_q;
  // Write completion rides with the final registered write strobe.
  assign bus.done        = wr_done_q | rd_done;
endmodule
